// File: rtl/rv_mul_issue.sv
// ============================================================================
//  Module  : rv_mul_issue
//  Brief   : MUL/MULW issue and writeback sequencer around a fixed-latency,
//            non-stallable multiplier, with an in-order result FIFO.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rv_mul_issue #(
    parameter int MUL_LAT   = 3,
    parameter int RES_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_word_i,
    input  logic [4:0]  req_rd_i,
    input  logic [63:0] req_op1_i,
    input  logic [63:0] req_op2_i,
    output logic [63:0] mul_op1_o,
    output logic [63:0] mul_op2_o,
    input  logic [63:0] mul_result_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [63:0] wb_data_o
);

    localparam int c_PTR_W = $clog2(RES_DEPTH);
    localparam int c_CNT_W = $clog2(RES_DEPTH + 1);
    localparam int c_INF_W = $clog2(MUL_LAT + 1);
    localparam int c_SUM_W = $clog2(MUL_LAT + RES_DEPTH + 1);

    localparam logic [c_SUM_W-1:0] c_DEPTH_S = c_SUM_W'(RES_DEPTH);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(RES_DEPTH);

    // Tag pipeline, one stage per multiplier stage
    logic [MUL_LAT-1:0]        tag_v_q,    tag_v_d;
    logic [MUL_LAT-1:0]        tag_word_q, tag_word_d;
    logic [MUL_LAT-1:0][4:0]   tag_rd_q,   tag_rd_d;

    // Result FIFO
    logic [RES_DEPTH-1:0][4:0]  fifo_rd_q,   fifo_rd_d;
    logic [RES_DEPTH-1:0][63:0] fifo_data_q, fifo_data_d;
    logic [c_PTR_W-1:0]         wr_ptr_q,    wr_ptr_d;
    logic [c_PTR_W-1:0]         rd_ptr_q,    rd_ptr_d;
    logic [c_CNT_W-1:0]         fifo_cnt_q,  fifo_cnt_d;

    logic [c_INF_W-1:0] w_inflight;
    logic [c_SUM_W-1:0] w_used;
    logic               w_acc;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [63:0]        w_cap_data;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            w_inflight = w_inflight + c_INF_W'(tag_v_q[i]);
        end
    end

    // Credits come only from registered state, so a pop frees a slot next cycle
    assign w_used      = c_SUM_W'(w_inflight) + c_SUM_W'(fifo_cnt_q);
    assign req_ready_o = ~flush_i & (w_used < c_DEPTH_S);
    assign w_acc       = req_valid_i & req_ready_o;

    assign mul_op1_o = w_acc ? req_op1_i : 64'd0;
    assign mul_op2_o = w_acc ? req_op2_i : 64'd0;

    assign w_full  = (fifo_cnt_q == c_FULL);
    assign w_empty = (fifo_cnt_q == '0);
    assign w_push  = tag_v_q[MUL_LAT-1] & ~flush_i;
    assign w_pop   = ~w_empty & wb_ready_i & ~flush_i;

    assign w_cap_data = tag_word_q[MUL_LAT-1]
                      ? {{32{mul_result_i[31]}}, mul_result_i[31:0]}
                      : mul_result_i;

    always_comb begin
        tag_v_d    = tag_v_q;
        tag_word_d = tag_word_q;
        tag_rd_d   = tag_rd_q;
        for (int i = MUL_LAT - 1; i > 0; i--) begin
            tag_v_d[i]    = tag_v_q[i-1];
            tag_word_d[i] = tag_word_q[i-1];
            tag_rd_d[i]   = tag_rd_q[i-1];
        end
        tag_v_d[0]    = w_acc;
        tag_word_d[0] = req_word_i;
        tag_rd_d[0]   = req_rd_i;
        // Killed ops keep flowing through the multiplier but are never captured
        if (flush_i) begin
            tag_v_d = '0;
        end
    end

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            if (w_push) begin
                fifo_rd_d[wr_ptr_q]   = tag_rd_q[MUL_LAT-1];
                fifo_data_d[wr_ptr_q] = w_cap_data;
                wr_ptr_d              = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + c_CNT_W'(1);
                2'b01:   fifo_cnt_d = fifo_cnt_q - c_CNT_W'(1);
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_v_q     <= '0;
            tag_word_q  <= '0;
            tag_rd_q    <= '0;
            fifo_rd_q   <= '0;
            fifo_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            tag_v_q     <= tag_v_d;
            tag_word_q  <= tag_word_d;
            tag_rd_q    <= tag_rd_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    assign wb_valid_o = ~w_empty;
    assign wb_rd_o    = fifo_rd_q[rd_ptr_q];
    assign wb_data_o  = fifo_data_q[rd_ptr_q];

    // The credit limit must make a capture into a full FIFO impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(w_push && w_full));

endmodule

`default_nettype wire

// File: tb/tb_rv_mul_issue.sv
// ============================================================================
//  Module  : tb_rv_mul_issue
//  Brief   : Self-checking bench for rv_mul_issue with a 3-stage multiplier model.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv_mul_issue;

    localparam int c_DEPTH = 4;

    logic        clk;
    logic        rstn;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_word_i;
    logic [4:0]  req_rd_i;
    logic [63:0] req_op1_i;
    logic [63:0] req_op2_i;
    logic [63:0] mul_op1_o;
    logic [63:0] mul_op2_o;
    logic [63:0] mul_result_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [63:0] wb_data_o;

    rv_mul_issue #(.MUL_LAT(3), .RES_DEPTH(c_DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_word_i   (req_word_i),
        .req_rd_i     (req_rd_i),
        .req_op1_i    (req_op1_i),
        .req_op2_i    (req_op2_i),
        .mul_op1_o    (mul_op1_o),
        .mul_op2_o    (mul_op2_o),
        .mul_result_i (mul_result_i),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-latency multiplier: product of the operands appears 3 cycles later
    logic [63:0] mpipe [3];
    always @(posedge clk) begin
        mpipe[0] <= mul_op1_o * mul_op2_o;
        mpipe[1] <= mpipe[0];
        mpipe[2] <= mpipe[1];
    end
    assign mul_result_i = mpipe[2];

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        int          avail;
    } exp_t;

    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] exp;
    } vec_t;

    exp_t        q[$];
    logic [4:0]  popped[$];
    logic [4:0]  sent[$];
    int          cyc;
    int          total;
    int          bad;
    logic        s_wbv;
    logic [4:0]  s_rd;
    logic [63:0] s_data;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [63:0] ref_mul(input logic w, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] p;
        p = a * b;
        return w ? {{32{p[31]}}, p[31:0]} : p;
    endfunction

    // One clock cycle: drive, compare against the outstanding-op model, advance
    task automatic step(input logic v, input logic w, input logic [4:0] rd,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic wbr, input logic fl, output logic acc);
        logic exp_ready;
        logic exp_wbv;
        exp_t e;
        req_valid_i = v;
        req_word_i  = w;
        req_rd_i    = rd;
        req_op1_i   = a;
        req_op2_i   = b;
        wb_ready_i  = wbr;
        flush_i     = fl;
        #1;
        exp_ready = !fl && (q.size() < c_DEPTH);
        exp_wbv   = (q.size() > 0) && (q[0].avail <= cyc);
        chk("req_ready", req_ready_o, exp_ready);
        chk("wb_valid", wb_valid_o, exp_wbv);
        if (exp_wbv) begin
            chk("wb_rd", wb_rd_o, q[0].rd);
            chk("wb_data", wb_data_o, q[0].data);
        end
        acc = v && exp_ready;
        chk("mul_op1", mul_op1_o, acc ? a : 64'd0);
        chk("mul_op2", mul_op2_o, acc ? b : 64'd0);
        s_wbv  = wb_valid_o;
        s_rd   = wb_rd_o;
        s_data = wb_data_o;
        if (wb_valid_o && wbr && !fl) popped.push_back(wb_rd_o);
        if (acc) sent.push_back(rd);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (exp_wbv && wbr) void'(q.pop_front());
            if (acc) begin
                e.rd    = rd;
                e.data  = ref_mul(w, a, b);
                e.avail = cyc + 4;
                q.push_back(e);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n, input logic wbr);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, wbr, 1'b0, a);
    endtask

    vec_t tv[7];

    initial begin
        logic        a;
        int          nacc;
        int          nwb;
        logic [4:0]  nrd;
        logic [63:0] ra;
        logic [63:0] rb;

        tv[0] = '{1'b0, 64'd3, 64'd5, 5'd7, 64'd15};
        tv[1] = '{1'b1, 64'h7FFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE};
        tv[2] = '{1'b0, 64'h7FFF_FFFF, 64'd2, 5'd4, 64'h0000_0000_FFFF_FFFE};
        tv[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 64'd1};
        tv[4] = '{1'b1, 64'h1_0000_0003, 64'd5, 5'd0, 64'd15};
        tv[5] = '{1'b1, 64'h8000_0000, 64'd1, 5'd12, 64'hFFFF_FFFF_8000_0000};
        tv[6] = '{1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 5'd20, 64'd0};

        total = 0; bad = 0; cyc = 0;
        rstn = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_word_i = 1'b0;
        req_rd_i = '0; req_op1_i = '0; req_op2_i = '0; wb_ready_i = 1'b0;
        @(posedge clk); cyc++;
        @(posedge clk); cyc++;
        #1;
        chk("rst_wb_valid", wb_valid_o, 1'b0);
        chk("rst_wb_rd", wb_rd_o, 5'd0);
        chk("rst_wb_data", wb_data_o, 64'd0);
        #2 rstn = 1'b1;

        // Single-op vectors: latency 4, one writeback cycle
        foreach (tv[i]) begin
            step(1'b1, tv[i].w, tv[i].rd, tv[i].a, tv[i].b, 1'b1, 1'b0, a);
            chk("tv_accept", a, 1'b1);
            idle(3, 1'b1);
            chk("tv_not_early", s_wbv, 1'b0);
            idle(1, 1'b1);
            chk("tv_wb_valid", s_wbv, 1'b1);
            chk("tv_wb_rd", s_rd, tv[i].rd);
            chk("tv_wb_data", s_data, tv[i].exp);
            idle(1, 1'b1);
            chk("tv_one_cycle", s_wbv, 1'b0);
        end

        // Back-pressure: only 4 credits, fifth accepted the cycle after the first pop
        popped.delete();
        nacc = 0; nrd = 5'd1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, nrd, 64'(i + 2), 64'd3, 1'b0, 1'b0, a);
            if (a) begin nacc++; nrd++; end
        end
        chk("bp_accepted", nacc, 4);
        step(1'b1, 1'b0, nrd, 64'd9, 64'd9, 1'b0, 1'b0, a);
        chk("bp_blocked", a, 1'b0);
        step(1'b1, 1'b0, nrd, 64'd9, 64'd9, 1'b1, 1'b0, a);
        chk("bp_pop_cycle", a, 1'b0);
        step(1'b1, 1'b0, nrd, 64'd9, 64'd9, 1'b1, 1'b0, a);
        chk("bp_fifth", a, 1'b1);
        idle(10, 1'b1);
        chk("bp_count", popped.size(), 5);
        for (int i = 0; i < 5 && i < popped.size(); i++) chk("bp_order", popped[i], 64'(i + 1));

        // Full FIFO with steady traffic: wrap pointers, no loss or duplication
        popped.delete(); sent.delete();
        nrd = 5'd0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, nrd, 64'(i), 64'd7, 1'b0, 1'b0, a);
            if (a) nrd++;
        end
        for (int i = 0; i < 30; i++) begin
            step(1'b1, i[0], nrd, 64'(i * 3 + 1), 64'h1_0000_0001, 1'b1, 1'b0, a);
            if (a) nrd++;
        end
        idle(8, 1'b1);
        chk("full_enough_ops", sent.size() >= 20, 1'b1);
        chk("full_count", popped.size(), sent.size());
        for (int i = 0; i < sent.size() && i < popped.size(); i++) chk("full_order", popped[i], sent[i]);

        // Flush with 2 buffered and 2 in flight
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'(10 + i), 64'd11, 64'(i), 1'b0, 1'b0, a);
        idle(1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1, 1'b1, a);
        chk("flush_ready", a, 1'b0);
        nwb = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1, 1'b1);
            if (s_wbv) nwb++;
        end
        chk("flush_no_wb", nwb, 0);
        step(1'b1, 1'b0, 5'd9, 64'd6, 64'd7, 1'b1, 1'b0, a);
        chk("flush_new_acc", a, 1'b1);
        idle(4, 1'b1);
        chk("flush_new_valid", s_wbv, 1'b1);
        chk("flush_new_data", s_data, 64'd42);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 5'(i + 1), 64'd5, 64'(i + 1), 1'b0, 1'b0, a);
        req_valid_i = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("arst_wb_valid", wb_valid_o, 1'b0);
        chk("arst_wb_rd", wb_rd_o, 5'd0);
        chk("arst_wb_data", wb_data_o, 64'd0);
        q.delete();
        @(posedge clk); cyc++;
        @(posedge clk); cyc++;
        #3 rstn = 1'b1;
        idle(8, 1'b1);
        step(1'b1, 1'b0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, a);
        idle(4, 1'b1);
        chk("arst_m1_valid", s_wbv, 1'b1);
        chk("arst_m1_data", s_data, 64'd1);
        idle(2, 1'b1);

        // Randomized traffic against the outstanding-op model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ra = 64'($urandom_range(0, 20)) - 64'd10;
                rb = 64'($urandom_range(0, 20)) - 64'd10;
            end else begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
            end
            step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 ra, rb, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, a);
        end
        idle(10, 1'b1);
        chk("rand_drained", wb_valid_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
